// File: rtl/my_if_pkg.sv
// Shared definitions for the my_if writer/reader pair: default sizes and payload type.
package my_if_pkg;

  localparam int MY_IF_DATA_W = 8;
  localparam int MY_IF_DEPTH  = 4;

  // Payload as carried on the AccessOut side of my_if (in_data/in_valid/in_ready).
  typedef logic [MY_IF_DATA_W-1:0] payload_t;

endpackage

// File: rtl/sr_fifo_core.sv
// Circular buffer storage with wrapping read/write pointers and occupancy count.
module sr_fifo_core
  import my_if_pkg::*;
#(
  parameter int DATA_W = MY_IF_DATA_W,
  parameter int DEPTH  = MY_IF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign dout  = mem[rd_ptr];

  // Storage write; contents are never observed before being written, so no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at DEPTH because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Occupancy tracks the net of push and pop in each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/module_sequential_reads.sv
// Buffered reader: accepts payloads from the writer, returns them in order on request,
// and keeps an accepted-payload counter, running XOR and sticky underflow flag.
module module_sequential_reads
  import my_if_pkg::*;
#(
  parameter int DATA_W = MY_IF_DATA_W,
  parameter int DEPTH  = MY_IF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     rd_req,
  output logic [DATA_W-1:0]        rd_data,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   count,
  output logic [7:0]               rx_total,
  output logic [DATA_W-1:0]        rx_xor,
  output logic                     underflow
);

  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [DATA_W-1:0] head;

  // Ready depends only on registered occupancy; a same-cycle pop never opens a slot.
  assign in_ready = ~full;

  // Handshake decode; a request against an empty buffer never bypasses a same-cycle push.
  always_comb begin
    push = in_valid & in_ready;
    pop  = rd_req & ~empty;
  end

  sr_fifo_core #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_core (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (in_data),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Registered read port: one-cycle valid pulse, data held between pops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= pop;
      if (pop) rd_data <= head;
    end
  end

  // Accepted-payload statistics, updated only on a completed transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_total <= '0;
      rx_xor   <= '0;
    end else if (push) begin
      rx_total <= rx_total + 8'd1;
      rx_xor   <= rx_xor ^ in_data;
    end
  end

  // Sticky underflow: any request seen while empty, held until reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underflow <= 1'b0;
    end else if (rd_req && empty) begin
      underflow <= 1'b1;
    end
  end

endmodule
